// File: rtl/stopwatch_if.sv
// stopwatch_if: raw button inputs and registered control outputs of the stopwatch controller.
interface stopwatch_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       btn_mode;
    logic       run;
    logic       clear_cnt;
    logic       lap_hold;
    logic       speedup;
    logic       slowdown;
    logic [1:0] state;
    modport master (
        output btn_start, btn_clear, btn_lap, btn_mode,
        input  run, clear_cnt, lap_hold, speedup, slowdown, state
    );
    modport slave (
        input  btn_start, btn_clear, btn_lap, btn_mode,
        output run, clear_cnt, lap_hold, speedup, slowdown, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: synchronizes and debounces four buttons into press pulses driving
// the run/pause/lap FSM and the speed-mode register; all outputs registered.
module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 4
) (
    input logic         clk,
    input logic         reset,
    stopwatch_if.slave  sw
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10, LAP = 2'b11} state_t;
    logic [3:0]       raw, s1_q, s2_q, lvl_q, lvl_d, prev_q, press_q;
    logic [3:0][15:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d, mode_nxt;
    logic             clr_d, run_q, lap_q, clr_q;
    logic             p_start, p_clear, p_lap, p_mode;
    // bit order: 0 start, 1 clear, 2 lap, 3 mode
    assign raw = {sw.btn_mode, sw.btn_lap, sw.btn_clear, sw.btn_start};
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++)
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == 16'(DEB_CYCLES - 1)) lvl_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 16'd1;
            end
    end
    assign {p_mode, p_lap, p_clear, p_start} = press_q;
    assign mode_nxt = (mode_q == 2'b00) ? 2'b10 : (mode_q == 2'b10) ? 2'b01 : 2'b00;
    // each state checks its legal pulses in priority order, so the highest legal one wins
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_clear) clr_d = 1'b1;
                else if (p_start) state_d = RUNNING;
                else if (p_mode) mode_d = mode_nxt;
            end
            RUNNING: begin
                if (p_start) state_d = PAUSED;
                else if (p_lap) state_d = LAP;
            end
            LAP: begin
                if (p_start) state_d = PAUSED;
                else if (p_lap) state_d = RUNNING;
            end
            default: begin
                if (p_clear) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (p_start) state_d = RUNNING;
                else if (p_mode) mode_d = mode_nxt;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            lvl_q   <= '0;
            prev_q  <= '0;
            press_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            mode_q  <= '0;
            run_q   <= 1'b0;
            lap_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            prev_q  <= lvl_q;
            press_q <= lvl_q & ~prev_q;
            state_q <= state_d;
            mode_q  <= mode_d;
            run_q   <= (state_d == RUNNING) || (state_d == LAP);
            lap_q   <= state_d == LAP;
            clr_q   <= clr_d;
        end
    end
    assign sw.state     = state_q;
    assign sw.run       = run_q;
    assign sw.lap_hold  = lap_q;
    assign sw.clear_cnt = clr_q;
    assign {sw.speedup, sw.slowdown} = mode_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed button sequences with hand-computed expected FSM/mode outputs.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic clr_seen;
    stopwatch_if sw();
    stopwatch_ctrl #(.DEB_CYCLES(4)) dut (.clk(clk), .reset(reset), .sw(sw));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        clr_seen = clr_seen | sw.clear_cnt;
    endtask
    task automatic drive(input logic [3:0] m);
        {sw.btn_mode, sw.btn_lap, sw.btn_clear, sw.btn_start} = m;
    endtask
    // mask bits: 0 start, 1 clear, 2 lap, 3 mode
    task automatic press(input logic [3:0] m, input int hold);
        clr_seen = 1'b0;
        drive(m);
        repeat (hold) tick();
        drive(4'b0000);
        repeat (8) tick();
    endtask
    initial begin
        drive(4'b0000);
        clr_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 8'(sw.state), 8'h0);
        check("rst_outs", {3'b0, sw.run, sw.clear_cnt, sw.lap_hold, sw.speedup, sw.slowdown}, 8'h0);
        reset = 1'b0;
        tick();
        press(4'b0001, 3);
        check("glitch_state", 8'(sw.state), 8'h0);
        check("glitch_run", 8'(sw.run), 8'h0);
        drive(4'b0001);
        repeat (7) tick();
        check("lat_e6_state", 8'(sw.state), 8'h0);
        check("lat_e6_run", 8'(sw.run), 8'h0);
        tick();
        check("lat_e7_state", 8'(sw.state), 8'h1);
        check("lat_e7_run", 8'(sw.run), 8'h1);
        repeat (12) tick();
        drive(4'b0000);
        repeat (8) tick();
        check("hold_one_pulse", 8'(sw.state), 8'h1);
        press(4'b0001, 4);
        check("pause_state", 8'(sw.state), 8'h2);
        check("pause_run", 8'(sw.run), 8'h0);
        clr_seen = 1'b0;
        drive(4'b0010);
        repeat (7) tick();
        check("clr_e6", {sw.state, sw.clear_cnt}, 8'b100);
        tick();
        check("clr_e7", {sw.state, sw.clear_cnt}, 8'b001);
        tick();
        check("clr_e8", 8'(sw.clear_cnt), 8'h0);
        drive(4'b0000);
        repeat (8) tick();
        press(4'b1000, 12);
        check("mode1", {sw.speedup, sw.slowdown}, 8'b10);
        press(4'b1000, 12);
        check("mode2", {sw.speedup, sw.slowdown}, 8'b01);
        press(4'b1000, 12);
        check("mode3", {sw.speedup, sw.slowdown}, 8'b00);
        press(4'b1010, 12);
        check("idle_clr_mode", {sw.state, sw.speedup, sw.slowdown}, 8'b0000);
        check("idle_clr_pulse", 8'(clr_seen), 8'h1);
        press(4'b0001, 12);
        check("run_again", 8'(sw.state), 8'h1);
        press(4'b0010, 12);
        check("run_clr_state", 8'(sw.state), 8'h1);
        check("run_clr_pulse", 8'(clr_seen), 8'h0);
        press(4'b1000, 12);
        check("run_mode", {sw.speedup, sw.slowdown}, 8'b00);
        press(4'b0101, 12);
        check("prio_state", 8'(sw.state), 8'h2);
        check("prio_lap_hold", 8'(sw.lap_hold), 8'h0);
        press(4'b1000, 12);
        check("pause_mode", {sw.speedup, sw.slowdown}, 8'b10);
        press(4'b0001, 12);
        press(4'b0100, 12);
        check("lap_state", {sw.state, sw.lap_hold, sw.run}, 8'b1111);
        press(4'b1000, 12);
        check("lap_mode", {sw.speedup, sw.slowdown}, 8'b10);
        reset = 1'b1;
        #1;
        check("async_rst", {sw.state, sw.run, sw.clear_cnt, sw.lap_hold, sw.speedup, sw.slowdown}, 8'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr_seen = 1'b0;
        repeat (10) tick();
        check("rst_no_clr", 8'(clr_seen), 8'h0);
        check("rst_stays_idle", 8'(sw.state), 8'h0);
        drive(4'b0001);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (7) tick();
        check("held_e6", 8'(sw.state), 8'h0);
        tick();
        check("held_e7", 8'(sw.state), 8'h1);
        drive(4'b0000);
        repeat (8) tick();
        press(4'b0100, 12);
        press(4'b0100, 12);
        check("lap_back_run", {sw.state, sw.lap_hold}, 8'b010);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
